// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants: opcodes, funct3 codes, ALU and result-select
// encodings, immediate formats, the control bundle and the canonical NOP.
package riscv_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_IALU   = 7'b0010011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_type_e;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  // addi x0,x0,0 -- what the F/D register holds after reset or a flush
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic        regWrite;
    logic        memWrite;
    logic        jump;
    logic        branch;
    logic        aluSrc;
    result_src_e resultSrc;
    alu_ctl_e    aluControl;
  } ctrl_t;

  // All controls inactive; used as the decode default and for illegal encodings
  localparam ctrl_t CTRL_BUBBLE = '{
    regWrite:   1'b0,
    memWrite:   1'b0,
    jump:       1'b0,
    branch:     1'b0,
    aluSrc:     1'b0,
    resultSrc:  RES_ALU,
    aluControl: ALU_ADD
  };

endpackage

// File: rtl/regfile.sv
// 32x32 integer register file: one synchronous write port, two asynchronous
// read ports, x0 hardwired to zero and write-before-read bypass.
module regfile
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        writeEn,
  input  logic [4:0]  writeAddr,
  input  logic [31:0] writeData,
  input  logic [4:0]  readAddr1,
  input  logic [4:0]  readAddr2,
  output logic [31:0] readData1,
  output logic [31:0] readData2
);

  logic [31:0] regs [32];
  logic        writeLive;

  // A write only takes effect outside reset and never targets x0
  assign writeLive = writeEn && !reset && (writeAddr != 5'd0);

  // Register storage: reset clears every entry and overrides a pending write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (writeLive) begin
      regs[writeAddr] <= writeData;
    end
  end

  // Read port 1: x0 reads zero, a same-cycle write to the address is forwarded
  always_comb begin
    readData1 = regs[readAddr1];
    if (readAddr1 == 5'd0) begin
      readData1 = '0;
    end else if (writeLive && (writeAddr == readAddr1)) begin
      readData1 = writeData;
    end
  end

  // Read port 2: same zero and forwarding rules as port 1
  always_comb begin
    readData2 = regs[readAddr2];
    if (readAddr2 == 5'd0) begin
      readData2 = '0;
    end else if (writeLive && (writeAddr == readAddr2)) begin
      readData2 = writeData;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Pipeline decode stage: F/D pipeline register, RV32I subset control decode,
// immediate extension and the register file read/writeback ports.
module decode_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stallD,
  input  logic        flushD,
  input  logic [31:0] instrF,
  input  logic [31:0] pcF,
  input  logic [31:0] pcPlus4F,
  input  logic        regWriteW,
  input  logic [4:0]  rdW,
  input  logic [31:0] resultW,
  output logic [31:0] rs1D,
  output logic [31:0] rs2D,
  output logic [4:0]  rs1AddrD,
  output logic [4:0]  rs2AddrD,
  output logic [4:0]  rdD,
  output logic [31:0] pcD,
  output logic [31:0] pcPlus4D,
  output logic [31:0] immExtD,
  output logic        RegWriteD,
  output logic        MemWriteD,
  output logic        JumpD,
  output logic        BranchD,
  output logic        ALUSrcD,
  output logic [1:0]  ResultSrcD,
  output logic [2:0]  ALUControlD,
  output logic        illegalD
);

  logic [31:0] instrD;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        isRtype;
  alu_ctl_e    aluOpCtl;
  logic        aluOpOk;
  ctrl_t       ctrl;
  imm_type_e   immType;
  logic        illegal;

  // F/D register: reset and flush insert a NOP bubble, stall holds, else load
  always_ff @(posedge clk) begin
    if (reset) begin
      instrD   <= NOP_INSTR;
      pcD      <= '0;
      pcPlus4D <= '0;
    end else if (flushD) begin
      instrD   <= NOP_INSTR;
      pcD      <= '0;
      pcPlus4D <= '0;
    end else if (!stallD) begin
      instrD   <= instrF;
      pcD      <= pcF;
      pcPlus4D <= pcPlus4F;
    end
  end

  assign opcode   = instrD[6:0];
  assign funct3   = instrD[14:12];
  assign funct7b5 = instrD[30];
  assign rdD      = instrD[11:7];
  assign rs1AddrD = instrD[19:15];
  assign rs2AddrD = instrD[24:20];
  assign isRtype  = (opcode == OP_RTYPE);

  // ALU operation from funct3, shared by R-type and I-ALU; only R-type may subtract
  always_comb begin
    aluOpCtl = ALU_ADD;
    aluOpOk  = 1'b1;
    case (funct3)
      F3_ADD_SUB: begin
        if (isRtype && funct7b5) begin
          aluOpCtl = ALU_SUB;
        end else begin
          aluOpCtl = ALU_ADD;
        end
      end
      F3_SLT:  aluOpCtl = ALU_SLT;
      F3_OR:   aluOpCtl = ALU_OR;
      F3_AND:  aluOpCtl = ALU_AND;
      default: aluOpOk  = 1'b0;
    endcase
  end

  // Main control decode; any unknown opcode or funct3 collapses to a bubble
  always_comb begin
    ctrl    = CTRL_BUBBLE;
    immType = IMM_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_LOAD: begin
        ctrl.regWrite  = 1'b1;
        ctrl.aluSrc    = 1'b1;
        ctrl.resultSrc = RES_MEM;
        immType        = IMM_I;
        illegal        = (funct3 != F3_WORD);
      end
      OP_STORE: begin
        ctrl.memWrite = 1'b1;
        ctrl.aluSrc   = 1'b1;
        immType       = IMM_S;
        illegal       = (funct3 != F3_WORD);
      end
      OP_RTYPE: begin
        ctrl.regWrite   = 1'b1;
        ctrl.aluControl = aluOpCtl;
        illegal         = !aluOpOk;
      end
      OP_IALU: begin
        ctrl.regWrite   = 1'b1;
        ctrl.aluSrc     = 1'b1;
        ctrl.aluControl = aluOpCtl;
        immType         = IMM_I;
        illegal         = !aluOpOk;
      end
      OP_BRANCH: begin
        ctrl.branch     = 1'b1;
        ctrl.aluControl = ALU_SUB;
        immType         = IMM_B;
        illegal         = (funct3 != F3_BEQ);
      end
      OP_JAL: begin
        ctrl.regWrite  = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.resultSrc = RES_PC4;
        immType        = IMM_J;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      ctrl    = CTRL_BUBBLE;
      immType = IMM_NONE;
    end
  end

  // Immediate extension by instruction format, sign taken from instr[31]
  always_comb begin
    immExtD = '0;
    case (immType)
      IMM_I:   immExtD = {{20{instrD[31]}}, instrD[31:20]};
      IMM_S:   immExtD = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
      IMM_B:   immExtD = {{20{instrD[31]}}, instrD[7], instrD[30:25], instrD[11:8], 1'b0};
      IMM_J:   immExtD = {{12{instrD[31]}}, instrD[19:12], instrD[20], instrD[30:21], 1'b0};
      default: immExtD = '0;
    endcase
  end

  assign RegWriteD   = ctrl.regWrite;
  assign MemWriteD   = ctrl.memWrite;
  assign JumpD       = ctrl.jump;
  assign BranchD     = ctrl.branch;
  assign ALUSrcD     = ctrl.aluSrc;
  assign ResultSrcD  = ctrl.resultSrc;
  assign ALUControlD = ctrl.aluControl;
  assign illegalD    = illegal;

  regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .writeEn   (regWriteW),
    .writeAddr (rdW),
    .writeData (resultW),
    .readAddr1 (rs1AddrD),
    .readAddr2 (rs2AddrD),
    .readData1 (rs1D),
    .readData2 (rs2D)
  );

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: register file reset/readback, a decode
// vector table checked through a scoreboard queue, and hand-written sequences
// for bypass, x0 writes, stall and flush.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallD;
  logic        flushD;
  logic [31:0] instrF;
  logic [31:0] pcF;
  logic [31:0] pcPlus4F;
  logic        regWriteW;
  logic [4:0]  rdW;
  logic [31:0] resultW;
  logic [31:0] rs1D;
  logic [31:0] rs2D;
  logic [4:0]  rs1AddrD;
  logic [4:0]  rs2AddrD;
  logic [4:0]  rdD;
  logic [31:0] pcD;
  logic [31:0] pcPlus4D;
  logic [31:0] immExtD;
  logic        RegWriteD;
  logic        MemWriteD;
  logic        JumpD;
  logic        BranchD;
  logic        ALUSrcD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic        illegalD;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] instr;
    logic        regWrite;
    logic        memWrite;
    logic        jump;
    logic        branch;
    logic        aluSrc;
    logic [1:0]  resultSrc;
    logic [2:0]  aluCtl;
    logic        illegal;
    logic        immCare;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] pc;
  } exp_t;

  vec_t        vecs [16];
  exp_t        sbq [$];
  logic [31:0] model [32];

  decode_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stallD      (stallD),
    .flushD      (flushD),
    .instrF      (instrF),
    .pcF         (pcF),
    .pcPlus4F    (pcPlus4F),
    .regWriteW   (regWriteW),
    .rdW         (rdW),
    .resultW     (resultW),
    .rs1D        (rs1D),
    .rs2D        (rs2D),
    .rs1AddrD    (rs1AddrD),
    .rs2AddrD    (rs2AddrD),
    .rdD         (rdD),
    .pcD         (pcD),
    .pcPlus4D    (pcPlus4D),
    .immExtD     (immExtD),
    .RegWriteD   (RegWriteD),
    .MemWriteD   (MemWriteD),
    .JumpD       (JumpD),
    .BranchD     (BranchD),
    .ALUSrcD     (ALUSrcD),
    .ResultSrcD  (ResultSrcD),
    .ALUControlD (ALUControlD),
    .illegalD    (illegalD)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v, input logic [31:0] pc);
    exp_t e;
    instrF   = v.instr;
    pcF      = pc;
    pcPlus4F = pc + 32'd4;
    e.v      = v;
    e.pc     = pc;
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input int idx);
    exp_t e;
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (sbq.size() == 0) begin
      checkVal({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      checkVal({tag, "_RegWrite"}, 32'(RegWriteD), 32'(e.v.regWrite));
      checkVal({tag, "_MemWrite"}, 32'(MemWriteD), 32'(e.v.memWrite));
      checkVal({tag, "_Jump"}, 32'(JumpD), 32'(e.v.jump));
      checkVal({tag, "_Branch"}, 32'(BranchD), 32'(e.v.branch));
      checkVal({tag, "_ALUSrc"}, 32'(ALUSrcD), 32'(e.v.aluSrc));
      checkVal({tag, "_ResultSrc"}, 32'(ResultSrcD), 32'(e.v.resultSrc));
      checkVal({tag, "_ALUControl"}, 32'(ALUControlD), 32'(e.v.aluCtl));
      checkVal({tag, "_illegal"}, 32'(illegalD), 32'(e.v.illegal));
      if (e.v.immCare) begin
        checkVal({tag, "_immExt"}, immExtD, e.v.imm);
      end
      checkVal({tag, "_rd"}, 32'(rdD), 32'(e.v.rd));
      checkVal({tag, "_rs1Addr"}, 32'(rs1AddrD), 32'(e.v.rs1a));
      checkVal({tag, "_rs2Addr"}, 32'(rs2AddrD), 32'(e.v.rs2a));
      checkVal({tag, "_pc"}, pcD, e.pc);
      checkVal({tag, "_pcPlus4"}, pcPlus4D, e.pc + 32'd4);
    end
  endtask

  task automatic readAllRegs(input string tag);
    logic [4:0] a1;
    logic [4:0] a2;
    for (int i = 0; i < 32; i++) begin
      a1       = 5'(i);
      a2       = 5'(31 - i);
      instrF   = {7'b0, a2, a1, 3'b000, 5'b0, 7'b0110011};
      pcF      = '0;
      pcPlus4F = 32'd4;
      tick();
      checkVal($sformatf("%s_rs1_x%0d", tag, i), rs1D, model[i]);
      checkVal($sformatf("%s_rs2_x%0d", tag, 31 - i), rs2D, model[31 - i]);
    end
  endtask

  initial begin
    // instr, RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc, ALUCtl, illegal, immCare, imm, rd, rs1, rs2
    vecs[0]  = '{32'h00500093, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 1'b0, 1'b1, 32'h00000005, 5'd1,  5'd0,  5'd5};
    vecs[1]  = '{32'hFE000EE3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b001, 1'b0, 1'b1, 32'hFFFFFFFC, 5'd29, 5'd0,  5'd0};
    vecs[2]  = '{32'h00812283, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'b000, 1'b0, 1'b1, 32'h00000008, 5'd5,  5'd2,  5'd8};
    vecs[3]  = '{32'hFE612E23, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 1'b0, 1'b1, 32'hFFFFFFFC, 5'd28, 5'd2,  5'd6};
    vecs[4]  = '{32'h402083B3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b001, 1'b0, 1'b1, 32'h00000000, 5'd7,  5'd1,  5'd2};
    vecs[5]  = '{32'h002083B3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 32'h00000000, 5'd7,  5'd1,  5'd2};
    vecs[6]  = '{32'h0041F433, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 1'b0, 1'b1, 32'h00000000, 5'd8,  5'd3,  5'd4};
    vecs[7]  = '{32'h0041E433, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b011, 1'b0, 1'b1, 32'h00000000, 5'd8,  5'd3,  5'd4};
    vecs[8]  = '{32'h0041A433, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b101, 1'b0, 1'b1, 32'h00000000, 5'd8,  5'd3,  5'd4};
    vecs[9]  = '{32'hFFF0A493, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b101, 1'b0, 1'b1, 32'hFFFFFFFF, 5'd9,  5'd1,  5'd31};
    vecs[10] = '{32'h40000093, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 1'b0, 1'b1, 32'h00000400, 5'd1,  5'd0,  5'd0};
    vecs[11] = '{32'h008000EF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 3'b000, 1'b0, 1'b1, 32'h00000008, 5'd1,  5'd0,  5'd8};
    vecs[12] = '{32'h0000007F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0, 32'h00000000, 5'd0,  5'd0,  5'd0};
    vecs[13] = '{32'h00209133, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0, 32'h00000000, 5'd2,  5'd1,  5'd2};
    vecs[14] = '{32'hFFDFF06F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 3'b000, 1'b0, 1'b1, 32'hFFFFFFFC, 5'd0,  5'd31, 5'd29};
    vecs[15] = '{32'hFE001EE3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0, 32'h00000000, 5'd29, 5'd0,  5'd0};

    reset     = 1'b1;
    stallD    = 1'b0;
    flushD    = 1'b0;
    instrF    = 32'h00500093;
    pcF       = 32'h00000040;
    pcPlus4F  = 32'h00000044;
    regWriteW = 1'b1;
    rdW       = 5'd7;
    resultW   = 32'h77777777;

    // Two reset cycles with a competing writeback, then check the NOP decode
    tick();
    tick();
    reset     = 1'b0;
    regWriteW = 1'b0;
    #1;
    checkVal("reset_instrD", dut.instrD, 32'h00000013);
    checkVal("reset_pcD", pcD, 32'h0);
    checkVal("reset_pcPlus4D", pcPlus4D, 32'h0);
    checkVal("reset_rs1D", rs1D, 32'h0);
    checkVal("reset_rs2D", rs2D, 32'h0);
    checkVal("reset_RegWriteD", 32'(RegWriteD), 32'd1);
    checkVal("reset_ALUSrcD", 32'(ALUSrcD), 32'd1);
    checkVal("reset_rdD", 32'(rdD), 32'd0);
    checkVal("reset_immExtD", immExtD, 32'h0);
    checkVal("reset_illegalD", 32'(illegalD), 32'd0);
    checkVal("reset_MemWriteD", 32'(MemWriteD), 32'd0);
    checkVal("reset_JumpD", 32'(JumpD), 32'd0);
    checkVal("reset_BranchD", 32'(BranchD), 32'd0);
    checkVal("reset_ResultSrcD", 32'(ResultSrcD), 32'd0);
    checkVal("reset_ALUControlD", 32'(ALUControlD), 32'd0);

    // Every register reads zero right after reset, even x7 which saw a write
    for (int i = 0; i < 32; i++) model[i] = '0;
    readAllRegs("postreset");

    // Fill x1..x31 through writeback, then read everything back
    instrF = 32'h00000013;
    for (int i = 1; i < 32; i++) begin
      regWriteW = 1'b1;
      rdW       = 5'(i);
      resultW   = (32'(i) * 32'h01010101) ^ 32'hA5A50000;
      model[i]  = resultW;
      tick();
    end
    regWriteW = 1'b0;
    readAllRegs("filled");

    // Reset again while a write is pending: reset wins and all registers clear
    reset     = 1'b1;
    regWriteW = 1'b1;
    rdW       = 5'd9;
    resultW   = 32'hFFFFFFFF;
    tick();
    tick();
    reset     = 1'b0;
    regWriteW = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    readAllRegs("rereset");

    // Decode vector table through the scoreboard
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i], 32'(256 + i * 16));
      tick();
      checkOutput(i);
    end

    // Writeback bypass: x3 written while the decoded instruction reads it
    instrF   = 32'h00018033;
    pcF      = 32'h0;
    pcPlus4F = 32'h4;
    tick();
    checkVal("bypass_before", rs1D, 32'h0);
    regWriteW = 1'b1;
    rdW       = 5'd3;
    resultW   = 32'hDEADBEEF;
    #1;
    checkVal("bypass_same_cycle", rs1D, 32'hDEADBEEF);
    tick();
    regWriteW = 1'b0;
    #1;
    checkVal("bypass_next_cycle", rs1D, 32'hDEADBEEF);

    // Writes to x0 are discarded and never forwarded
    instrF = 32'h00000033;
    tick();
    regWriteW = 1'b1;
    rdW       = 5'd0;
    resultW   = 32'h00001234;
    #1;
    checkVal("x0_write_same_cycle", rs1D, 32'h0);
    tick();
    regWriteW = 1'b0;
    #1;
    checkVal("x0_write_next_cycle", rs1D, 32'h0);

    // addi x1,x0,5 at pc 0x10 appears one cycle after it is presented
    instrF   = 32'h00500093;
    pcF      = 32'h00000010;
    pcPlus4F = 32'h00000014;
    tick();
    checkVal("addi_pcD", pcD, 32'h10);
    checkVal("addi_rdD", 32'(rdD), 32'd1);
    checkVal("addi_immExtD", immExtD, 32'd5);
    checkVal("addi_RegWriteD", 32'(RegWriteD), 32'd1);
    checkVal("addi_ALUSrcD", 32'(ALUSrcD), 32'd1);

    // Stall three cycles with changing fetch data; writeback still lands in x4
    stallD    = 1'b1;
    regWriteW = 1'b1;
    rdW       = 5'd4;
    resultW   = 32'hCAFE0004;
    for (int k = 0; k < 3; k++) begin
      instrF   = 32'h0041F433 + 32'(k * 128);
      pcF      = 32'(512 + k * 4);
      pcPlus4F = 32'(516 + k * 4);
      tick();
      regWriteW = 1'b0;
      checkVal($sformatf("stall%0d_instrD", k), dut.instrD, 32'h00500093);
      checkVal($sformatf("stall%0d_pcD", k), pcD, 32'h10);
      checkVal($sformatf("stall%0d_pcPlus4D", k), pcPlus4D, 32'h14);
      checkVal($sformatf("stall%0d_immExtD", k), immExtD, 32'd5);
    end

    // Flush wins over stall and loads the NOP bubble
    flushD   = 1'b1;
    instrF   = 32'h402083B3;
    pcF      = 32'h00000300;
    pcPlus4F = 32'h00000304;
    tick();
    flushD = 1'b0;
    stallD = 1'b0;
    checkVal("flush_instrD", dut.instrD, 32'h00000013);
    checkVal("flush_pcD", pcD, 32'h0);
    checkVal("flush_pcPlus4D", pcPlus4D, 32'h0);
    checkVal("flush_rdD", 32'(rdD), 32'd0);
    checkVal("flush_RegWriteD", 32'(RegWriteD), 32'd1);
    checkVal("flush_ALUSrcD", 32'(ALUSrcD), 32'd1);
    checkVal("flush_ALUControlD", 32'(ALUControlD), 32'd0);

    // The write issued during the stall is visible afterwards
    instrF   = 32'h00020033;
    pcF      = 32'h0;
    pcPlus4F = 32'h4;
    tick();
    checkVal("stall_write_x4", rs1D, 32'hCAFE0004);

    checkVal("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have ports clk, in, 1, sole clock; all state updates on posedge clk.
REQ-002 SHALL have ports reset, in, 1; reset is synchronous and active-high.
REQ-003 SHALL have ports stallD, in, 1; hold F/D register.
REQ-004 SHALL have ports flushD, in, 1; load bubble into F/D register.
REQ-005 SHALL have ports instrF, pcF, pcPlus4F, in, 32 each; fetch-stage outputs.
REQ-006 SHALL have ports regWriteW, in, 1; rdW, in, 5; resultW, in, 32; writeback port.
REQ-007 SHALL have ports rs1D, rs2D, out, 32; register read data.
REQ-008 SHALL have ports rs1AddrD, rs2AddrD, rdD, out, 5; instr[19:15], [24:20], [11:7], for hazard unit and D/E register.
REQ-009 SHALL have ports pcD, pcPlus4D, immExtD, out, 32.
REQ-010 SHALL have ports RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, out, 1 each; ResultSrcD, out, 2; ALUControlD, out, 3; illegalD, out, 1.

Function
REQ-011 SHALL hold F/D register instrD, pcD, pcPlus4D; priority reset > flushD > stallD > load.
REQ-012 SHALL, on load, capture instrF/pcF/pcPlus4F; decoded outputs valid combinationally from instrD the following cycle (1-cycle latency).
REQ-013 SHALL, on stallD=1 with flushD=0, keep instrD/pcD/pcPlus4D unchanged.
REQ-014 SHALL, on flushD=1 (regardless of stallD), load instrD=32'h00000013 (addi x0,x0,0), pcD=0, pcPlus4D=0.
REQ-015 SHALL decode opcodes: 0000011 lw, 0100011 sw, 0110011 R-type, 0010011 I-ALU, 1100011 beq, 1101111 jal.
REQ-016 SHALL set controls: lw RegWrite=1 ALUSrc=1 ResultSrc=01; sw MemWrite=1 ALUSrc=1; R RegWrite=1; I-ALU RegWrite=1 ALUSrc=1; beq Branch=1 ALUControl=001; jal RegWrite=1 Jump=1 ResultSrc=10; unlisted controls 0, ResultSrc 00.
REQ-017 SHALL set ALUControl: add 000, sub 001, and 010, or 011, slt 101; lw/sw/jal 000; R-type sub when funct3=000 and funct7[5]=1; addi never sub.
REQ-018 SHALL treat unknown opcode or unsupported funct3 as illegal: illegalD=1, all control outputs 0 (bubble).
REQ-019 SHALL extend immediates by type: I instr[31:20], S {[31:25],[11:7]}, B {[31],[7],[30:25],[11:8],0}, J {[31],[19:12],[20],[30:21],0}, all sign-extended from instr[31]; R-type immExtD=0.
REQ-020 SHALL contain 32x32 register file, one write port, two async read ports.
REQ-021 SHALL write resultW to rdW at posedge when regWriteW=1 and rdW!=0.
REQ-022 SHALL read x0 as 0 always; writes to x0 ignored.
REQ-023 SHALL bypass: if regWriteW=1, rdW!=0, rdW==rsXAddrD, rsXD=resultW same cycle (write-before-read).
REQ-024 SHALL allow writeback during stall or flush; register file writes never gated by stallD/flushD.

Reset
REQ-025 SHALL, on reset, set instrD=32'h00000013, pcD=0, pcPlus4D=0, all 32 registers=0.
REQ-026 SHALL, during reset cycle, ignore regWriteW; reset wins over write.
REQ-027 SHALL, after reset release, present nop decode: RegWriteD=1, rdD=0, ALUSrcD=1, immExtD=0, illegalD=0, other controls 0.

Structure
REQ-028 SHALL place opcode constants, ALUControl encodings, ResultSrc encodings, NOP constant in shared package riscv_pkg.
REQ-029 SHALL implement register file as sub-module regfile; decoder and immediate extension inline.
REQ-030 SHALL contain no latches; combinational decode fully specified with defaults.

Verification
REQ-031 SHALL cover: reset 2 cycles -> rs1D=rs2D=0, instrD=0x00000013, all regs read 0.
REQ-032 SHALL cover: instrF=0x00500093 (addi x1,x0,5), pcF=0x10 -> next cycle RegWriteD=1, ALUSrcD=1, immExtD=5, rdD=1, pcD=0x10.
REQ-033 SHALL cover: regWriteW=1 rdW=3 resultW=0xDEADBEEF while instrD reads x3 -> rs1D=0xDEADBEEF same cycle; next cycle still 0xDEADBEEF.
REQ-034 SHALL cover: regWriteW=1 rdW=0 resultW=0x1234 -> x0 reads 0.
REQ-035 SHALL cover: stallD=1 three cycles with changing instrF -> instrD/pcD constant; stallD=1 with flushD=1 -> nop loaded.
REQ-036 SHALL cover: instrF=0xFE000EE3 (beq, offset -4) -> BranchD=1, ALUControlD=001, immExtD=0xFFFFFFFC; opcode 0x7F -> illegalD=1, controls 0.
